pipelined_addsub: RTL and testbench
===================================

Name: pipelined_addsub

Overview:
Parametrised, pipelined integer adder/subtractor, successor to the team's 32-bit single-cycle Brent-Kung add/sub. The carry chain is split into STAGES segments, with one segment resolved per clock, so wide operands close timing at high clock rates. Adds valid/ready handshaking with full backpressure, a borrow-aware carry-in for multi-word chaining, and result flags. Sits between operand-issue logic and the ALU result/writeback path.

Parameters:
WIDTH, 32, operand and result width in bits; must be divisible by STAGES.
STAGES, 4, number of pipeline stages; each resolves WIDTH/STAGES bits. Legal range 1..WIDTH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sub  input  1  0 = add, 1 = subtract
cin  input  1  carry-in for add; borrow-in for subtract
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts the result
sum  output  WIDTH  result
cout  output  1  add: carry-out; sub: 1 = no borrow (A >= B + cin, unsigned)
ovf  output  1  signed two's-complement overflow
zero  output  1  sum == 0
neg  output  1  sum[WIDTH-1]

Behaviour:
- Reset: one clock, asynchronous, active-low (rst_n). On assertion, all stage valid bits, out_valid, sum, cout, ovf, zero and neg are cleared to 0 immediately, and any in-flight beats are discarded. in_ready is 1 once out_valid = 0.
- Arithmetic: effective B is b XOR {WIDTH{sub}}. Carry0 is cin for add and ~cin for sub, giving A+B+cin or A-B-cin. All operations are modulo 2^WIDTH.
- Segmentation: stage k (0..STAGES-1) adds bits [k*SEG +: SEG] using the carry from stage k-1's register. SEG = WIDTH/STAGES.
  - Unconsumed upper operand segments travel with the beat through skew registers.
  - Computed lower segments are carried forward in the sum register.
- Latency: a beat accepted on cycle N (in_valid & in_ready) presents out_valid on cycle N+STAGES when there is no stall. Throughput is one beat per cycle.
- Flags: registered alongside the final sum segment.
  - cout is the final carry.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero and neg are computed from the full final sum.
- Handshake:
  - Stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - During a stall every stage register holds, bubbles included; there is no bubble collapsing.
  - A beat is transferred out on out_valid & out_ready.
  - On the same cycle, a new input may be accepted and all stages advance.
- Output stability: while out_valid = 1 and out_ready = 0, sum and all flags hold their values.
- Bubbles: a stage whose valid bit is 0 may carry arbitrary data. out_valid reflects only the last stage's valid bit.
- in_valid = 0 inserts a bubble. Inputs are sampled only on accept.
- Corner cases:
  - With sub = 1 and cin = 0, a == b gives sum = 0, cout = 1, zero = 1.
  - With add and cin = 1, all-ones + 0 wraps to 0 with cout = 1.
  - STAGES = 1 degenerates to a single registered full-width add with latency 1.
- Reset mid-operation: pending beats are lost and no partial result appears after reset release. The first output after release comes from the first beat accepted after release.

Test Plan:
1. WIDTH=32, STAGES=4, add a=0xFFFFFFFF b=0x00000000 cin=1 -> 4 cycles later sum=0x00000000, cout=1, zero=1, ovf=0, neg=0.
2. Add a=0x7FFFFFFF b=0x00000001 cin=0 -> sum=0x80000000, ovf=1, neg=1, cout=0. Then sub a=0x80000000 b=0x00000001 cin=0 -> sum=0x7FFFFFFF, ovf=1, cout=1.
3. Sub a=5 b=7 cin=0 -> sum=0xFFFFFFFE, cout=0, neg=1. Then sub a=7 b=7 cin=0 -> sum=0, cout=1, zero=1. Then sub a=7 b=7 cin=1 -> sum=0xFFFFFFFF, cout=0.
4. Stream 16 back-to-back random beats with out_ready held low for 3 cycles mid-stream -> in_ready=0 during the stall, sum and flags stable, all 16 results in order matching the reference model, no loss or duplication.
5. Accept 3 beats, then pull rst_n low for one cycle asynchronously (mid-cycle) -> out_valid and all outputs 0 immediately; no stale results after release; a new beat emerges after exactly STAGES cycles.
6. Repeat scenarios 1-4 with (WIDTH=64, STAGES=8) and (WIDTH=16, STAGES=1) -> correct latency (8 and 1 cycles) and bit-exact results and flags.

Source files
------------

// File: rtl/pipelined_addsub_if.sv
`default_nettype none
// ============================================================================
// pipelined_addsub_if : operand/result handshake bundle for pipelined_addsub
// Revision 1.0
// ============================================================================
interface pipelined_addsub_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             zero;
   logic             neg;

   modport master (
      output in_valid, a, b, sub, cin, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, zero, neg
   );

   modport slave (
      input  in_valid, a, b, sub, cin, out_ready,
      output in_ready, out_valid, sum, cout, ovf, zero, neg
   );
endinterface
`default_nettype wire

// File: rtl/pipelined_addsub.sv
`default_nettype none
// ============================================================================
// pipelined_addsub : segmented-carry add/sub, one WIDTH/STAGES slice per clock
// Revision 1.0
// ============================================================================
module pipelined_addsub #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   pipelined_addsub_if.slave bus
);

   localparam int SEG  = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;

   logic [STAGES-1:0] valid_q, valid_d;
   logic [STAGES-1:0] carry_q, carry_d;
   logic [WIDTH-1:0]  a_q   [STAGES];
   logic [WIDTH-1:0]  a_d   [STAGES];
   logic [WIDTH-1:0]  b_q   [STAGES];
   logic [WIDTH-1:0]  b_d   [STAGES];
   logic [WIDTH-1:0]  sum_q [STAGES];
   logic [WIDTH-1:0]  sum_d [STAGES];
   logic              ovf_q, ovf_d;
   logic              zero_q, zero_d;
   logic              neg_q, neg_d;

   // Per-stage inputs: stage 0 takes the bus, stage k takes register k-1.
   logic [STAGES-1:0] v_src;
   logic [STAGES-1:0] c_src;
   logic [WIDTH-1:0]  a_src  [STAGES];
   logic [WIDTH-1:0]  b_src  [STAGES];
   logic [WIDTH-1:0]  s_src  [STAGES];
   logic [WIDTH-1:0]  s_next [STAGES];
   logic [SEG:0]      seg_res[STAGES];

   logic stall;
   logic advance;

   assign stall   = valid_q[LAST] & ~bus.out_ready;
   assign advance = ~stall;

   always_comb begin
      v_src[0] = bus.in_valid;
      a_src[0] = bus.a;
      b_src[0] = bus.b ^ {WIDTH{bus.sub}};
      s_src[0] = '0;
      c_src[0] = bus.cin ^ bus.sub;
      for (int k = 1; k < STAGES; k++) begin
         v_src[k] = valid_q[k-1];
         a_src[k] = a_q[k-1];
         b_src[k] = b_q[k-1];
         s_src[k] = sum_q[k-1];
         c_src[k] = carry_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         seg_res[k] = {1'b0, a_src[k][k*SEG +: SEG]}
                    + {1'b0, b_src[k][k*SEG +: SEG]}
                    + {{SEG{1'b0}}, c_src[k]};
         s_next[k]  = s_src[k];
         s_next[k][k*SEG +: SEG] = seg_res[k][SEG-1:0];
      end
   end

   // A stall freezes every stage, bubbles included.
   always_comb begin
      valid_d = valid_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      neg_d   = neg_q;
      for (int k = 0; k < STAGES; k++) begin
         a_d[k]   = a_q[k];
         b_d[k]   = b_q[k];
         sum_d[k] = sum_q[k];
      end
      if (advance) begin
         for (int k = 0; k < STAGES; k++) begin
            valid_d[k] = v_src[k];
            carry_d[k] = seg_res[k][SEG];
            a_d[k]     = a_src[k];
            b_d[k]     = b_src[k];
            sum_d[k]   = s_next[k];
         end
         // Same-sign operands giving an opposite-sign result is exactly
         // carry-into-MSB differing from carry-out-of-MSB.
         ovf_d  = (a_src[LAST][WIDTH-1] ~^ b_src[LAST][WIDTH-1])
                & (s_next[LAST][WIDTH-1] ^ a_src[LAST][WIDTH-1]);
         zero_d = ~|s_next[LAST];
         neg_d  = s_next[LAST][WIDTH-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         carry_q <= '0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         neg_q   <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            sum_q[k] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
         neg_q   <= neg_d;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= a_d[k];
            b_q[k]   <= b_d[k];
            sum_q[k] <= sum_d[k];
         end
      end
   end

   // Operands leaving the last stage have no consumer.
   logic unused_last_operands;
   assign unused_last_operands = ^{a_q[LAST], b_q[LAST]};

   assign bus.in_ready  = ~stall;
   assign bus.out_valid = valid_q[LAST];
   assign bus.sum       = sum_q[LAST];
   assign bus.cout      = carry_q[LAST];
   assign bus.ovf       = ovf_q;
   assign bus.zero      = zero_q;
   assign bus.neg       = neg_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_addsub.sv
`default_nettype none
// ============================================================================
// tb_pipelined_addsub : three configurations (32/4, 64/8, 16/1) driven in
// lockstep against a scoreboard of reference results. Revision 1.0
// ============================================================================
module tb_pipelined_addsub;

   typedef struct packed {
      logic [63:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
      logic        neg;
   } res_t;

   typedef struct {
      res_t r;
      int   acc;
      bit   lat;
   } ent_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [63:0] drv_a     = '0;
   logic [63:0] drv_b     = '0;
   logic        drv_sub   = 1'b0;
   logic        drv_cin   = 1'b0;
   logic        drv_valid = 1'b0;
   logic        drv_ready = 1'b1;

   pipelined_addsub_if #(.WIDTH(32)) bus32 ();
   pipelined_addsub_if #(.WIDTH(64)) bus64 ();
   pipelined_addsub_if #(.WIDTH(16)) bus16 ();

   assign bus32.in_valid = drv_valid;  assign bus32.out_ready = drv_ready;
   assign bus32.a = drv_a[31:0];       assign bus32.b = drv_b[31:0];
   assign bus32.sub = drv_sub;         assign bus32.cin = drv_cin;
   assign bus64.in_valid = drv_valid;  assign bus64.out_ready = drv_ready;
   assign bus64.a = drv_a;             assign bus64.b = drv_b;
   assign bus64.sub = drv_sub;         assign bus64.cin = drv_cin;
   assign bus16.in_valid = drv_valid;  assign bus16.out_ready = drv_ready;
   assign bus16.a = drv_a[15:0];       assign bus16.b = drv_b[15:0];
   assign bus16.sub = drv_sub;         assign bus16.cin = drv_cin;

   pipelined_addsub #(.WIDTH(32), .STAGES(4)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
   pipelined_addsub #(.WIDTH(64), .STAGES(8)) u_dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));
   pipelined_addsub #(.WIDTH(16), .STAGES(1)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

   ent_t sbq [3][$];
   res_t prev_r [3];
   bit   prev_stall [3];

   function automatic int wid(input int i);
      return (i == 0) ? 32 : (i == 1) ? 64 : 16;
   endfunction

   function automatic int stg(input int i);
      return (i == 0) ? 4 : (i == 1) ? 8 : 1;
   endfunction

   function automatic res_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic sub, input logic cin);
      res_t        r;
      logic [63:0] mask, am, bm;
      logic [64:0] full, low;
      logic        c0;
      mask   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      am     = a & mask;
      bm     = (sub ? ~b : b) & mask;
      c0     = sub ? ~cin : cin;
      full   = {1'b0, am} + {1'b0, bm} + {64'd0, c0};
      r.sum  = full[63:0] & mask;
      r.cout = full[w];
      low    = {1'b0, am & (mask >> 1)} + {1'b0, bm & (mask >> 1)} + {64'd0, c0};
      r.ovf  = low[w-1] ^ r.cout;
      r.zero = (r.sum == 64'd0);
      r.neg  = r.sum[w-1];
      return r;
   endfunction

   function automatic res_t get_out(input int i);
      res_t r;
      case (i)
         0: begin
            r.sum = 64'(bus32.sum); r.cout = bus32.cout; r.ovf = bus32.ovf;
            r.zero = bus32.zero;    r.neg = bus32.neg;
         end
         1: begin
            r.sum = bus64.sum;      r.cout = bus64.cout; r.ovf = bus64.ovf;
            r.zero = bus64.zero;    r.neg = bus64.neg;
         end
         default: begin
            r.sum = 64'(bus16.sum); r.cout = bus16.cout; r.ovf = bus16.ovf;
            r.zero = bus16.zero;    r.neg = bus16.neg;
         end
      endcase
      return r;
   endfunction

   function automatic logic get_vld(input int i);
      return (i == 0) ? bus32.out_valid : (i == 1) ? bus64.out_valid : bus16.out_valid;
   endfunction

   function automatic logic get_rdy(input int i);
      return (i == 0) ? bus32.in_ready : (i == 1) ? bus64.in_ready : bus16.in_ready;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic monitor_one(input int i);
      res_t  o;
      logic  v;
      ent_t  e;
      string w;
      w = $sformatf("w%0d", wid(i));
      v = get_vld(i);
      o = get_out(i);
      if (prev_stall[i]) begin
         chk({w, "_hold_valid"}, 128'(v), 128'(1'b1));
         chk({w, "_hold_data"}, 128'(o), 128'(prev_r[i]));
      end
      if (v && drv_ready) begin
         if (sbq[i].size() == 0) begin
            chk({w, "_spurious_out_valid"}, 128'(v), 128'(1'b0));
         end else begin
            e = sbq[i].pop_front();
            chk({w, "_sum"},  128'(o.sum),  128'(e.r.sum));
            chk({w, "_cout"}, 128'(o.cout), 128'(e.r.cout));
            chk({w, "_ovf"},  128'(o.ovf),  128'(e.r.ovf));
            chk({w, "_zero"}, 128'(o.zero), 128'(e.r.zero));
            chk({w, "_neg"},  128'(o.neg),  128'(e.r.neg));
            if (e.lat) chk({w, "_latency"}, 128'(cyc - e.acc), 128'(stg(i)));
         end
      end
      prev_stall[i] = v & ~drv_ready;
      prev_r[i]     = o;
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rst_n) monitor_one(i);
         else       prev_stall[i] = 1'b0;
      end
   end

   // One clock of stimulus: out_ready is applied first so in_ready is settled
   // before deciding whether a beat is offered.
   task automatic cycle(input bit want, input logic rdy, input logic [63:0] a,
                        input logic [63:0] b, input logic sub, input logic cin,
                        input bit lat, output bit took);
      ent_t e;
      @(posedge clk);
      #1;
      drv_ready = rdy;
      drv_valid = 1'b0;
      #1;
      took = 1'b0;
      if (want && bus32.in_ready && bus64.in_ready && bus16.in_ready) begin
         drv_a = a; drv_b = b; drv_sub = sub; drv_cin = cin;
         drv_valid = 1'b1;
         took = 1'b1;
         for (int i = 0; i < 3; i++) begin
            e.r   = model(wid(i), a, b, sub, cin);
            e.acc = cyc;
            e.lat = lat;
            sbq[i].push_back(e);
         end
      end
   endtask

   task automatic send(input logic [63:0] a, input logic [63:0] b,
                       input logic sub, input logic cin, input bit lat);
      bit took;
      int tries;
      took  = 1'b0;
      tries = 0;
      while (!took && tries < 50) begin
         cycle(1'b1, 1'b1, a, b, sub, cin, lat, took);
         tries++;
      end
      if (!took) chk("send_timeout", 128'(took), 128'(1'b1));
   endtask

   task automatic drain();
      bit took;
      int tries;
      tries = 0;
      while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && tries < 60) begin
         cycle(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0, took);
         tries++;
      end
      cycle(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0, took);
      chk("drain_pending", 128'(sbq[0].size() + sbq[1].size() + sbq[2].size()), 128'(0));
   endtask

   task automatic check_cleared(input string tag);
      res_t o;
      for (int i = 0; i < 3; i++) begin
         o = get_out(i);
         chk($sformatf("%s_w%0d_out_valid", tag, wid(i)), 128'(get_vld(i)), 128'(1'b0));
         chk($sformatf("%s_w%0d_outputs", tag, wid(i)), 128'(o), 128'(0));
         chk($sformatf("%s_w%0d_in_ready", tag, wid(i)), 128'(get_rdy(i)), 128'(1'b1));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit took;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check_cleared("reset");
      @(posedge clk);
      #3 rst_n = 1'b1;

      // Wrap, signed overflow at each width's max-positive / min-negative, borrows.
      send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1, 1'b1);
      send(64'h0000_0000_FFFF_FFFF, 64'h0, 1'b0, 1'b1, 1'b1);
      send(64'h0000_0000_7FFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b1);
      send(64'h0000_0000_0000_7FFF, 64'h1, 1'b0, 1'b0, 1'b1);
      send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b1);
      send(64'h0000_0000_8000_0000, 64'h1, 1'b1, 1'b0, 1'b1);
      send(64'h0000_0000_0000_8000, 64'h1, 1'b1, 1'b0, 1'b1);
      send(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, 1'b1);
      send(64'd5, 64'd7, 1'b1, 1'b0, 1'b1);
      send(64'd7, 64'd7, 1'b1, 1'b0, 1'b1);
      send(64'd7, 64'd7, 1'b1, 1'b1, 1'b1);
      drain();

      // Back-to-back random stream with a 3-cycle output stall after 10 beats.
      for (int n = 0; n < 16; n++) begin
         if (n == 10) begin
            for (int s = 0; s < 3; s++) begin
               cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, took);
               for (int i = 0; i < 3; i++)
                  chk($sformatf("stall_w%0d_in_ready", wid(i)), 128'(get_rdy(i)), 128'(1'b0));
            end
         end
         send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom), 1'b0);
      end
      drain();

      // Asynchronous reset with beats in flight.
      for (int n = 0; n < 3; n++)
         send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom), 1'b0);
      @(posedge clk);
      #3;
      drv_valid = 1'b0;
      rst_n     = 1'b0;
      #1;
      check_cleared("async_reset");
      for (int i = 0; i < 3; i++) sbq[i].delete();
      @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (10) cycle(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0, took);
      send(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b0, 1'b1, 1'b1);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
